// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and codes for the load/store unit.
// FSM states, read-type codes, store masks and result error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  localparam logic [2:0] RT_LB  = 3'd0;
  localparam logic [2:0] RT_LH  = 3'd1;
  localparam logic [2:0] RT_LW  = 3'd2;
  localparam logic [2:0] RT_LBU = 3'd3;
  localparam logic [2:0] RT_LHU = 3'd4;

  localparam logic [7:0] WM_BYTE = 8'h01;
  localparam logic [7:0] WM_HALF = 8'h03;
  localparam logic [7:0] WM_WORD = 8'h0F;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LD_MIS  = 3'd1;
  localparam logic [2:0] ERR_ST_MIS  = 3'd2;
  localparam logic [2:0] ERR_BUS     = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;

endpackage

// File: rtl/lsu_rdata_align.sv
// lsu_rdata_align: shifts the bus read word down by the byte offset
// and sign/zero-extends it per read type (word, offset, rtype -> data).
module lsu_rdata_align (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  rtype,
  output logic [31:0] data
);
  import lsu_pkg::*;

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = '0;
    case (rtype)
      RT_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      RT_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      RT_LW:   data = shifted;
      RT_LBU:  data = {24'd0, shifted[7:0]};
      RT_LHU:  data = {16'd0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: accepts one load/store, checks it, runs one bus req/resp
// and returns extended data or an error code on the out_* handshake.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [7:0]        in_wmask,
  input  logic [2:0]        in_rtype,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wen,
  output logic [3:0]        bus_req_wstrb,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_resp_valid,
  output logic              bus_resp_ready,
  input  logic [DATA_W-1:0] bus_resp_rdata,
  input  logic              bus_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [2:0]        out_err
);
  import lsu_pkg::*;

  state_t state, state_nxt;

  logic              wen_q;
  logic [3:0]        wmask_q;
  logic [2:0]        rtype_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        err_q;
  logic [2:0]        dec_err;
  logic [DATA_W-1:0] ld_data;
  logic              accept;
  logic              resp_hs;

  assign accept  = in_valid & in_ready;
  assign resp_hs = (state == S_RESP) & bus_resp_valid;

  // Decode straight from the inputs so the error is known at acceptance.
  always_comb begin
    dec_err = ERR_NONE;
    if (in_wen) begin
      case (in_wmask)
        WM_BYTE: dec_err = ERR_NONE;
        WM_HALF: if (in_addr[0]) dec_err = ERR_ST_MIS;
        WM_WORD: if (in_addr[1:0] != 2'b00) dec_err = ERR_ST_MIS;
        default: dec_err = ERR_ILLEGAL;
      endcase
    end else begin
      case (in_rtype)
        RT_LB, RT_LBU: dec_err = ERR_NONE;
        RT_LH, RT_LHU: if (in_addr[0]) dec_err = ERR_LD_MIS;
        RT_LW: if (in_addr[1:0] != 2'b00) dec_err = ERR_LD_MIS;
        default: dec_err = ERR_ILLEGAL;
      endcase
    end
  end

  lsu_rdata_align u_align (
    .word   (bus_resp_rdata),
    .offset (addr_q[1:0]),
    .rtype  (rtype_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    bus_req_valid  = 1'b0;
    bus_resp_ready = 1'b0;
    out_valid      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (dec_err != ERR_NONE) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus_resp_ready = 1'b1;
        if (bus_resp_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wmask_q <= '0;
      rtype_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      if (accept) begin
        wen_q   <= in_wen;
        wmask_q <= in_wmask[3:0];
        rtype_q <= in_rtype;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rdata_q <= '0;
        err_q   <= dec_err;
      end
      if (resp_hs) begin
        err_q   <= bus_resp_err ? ERR_BUS : ERR_NONE;
        rdata_q <= (bus_resp_err | wen_q) ? '0 : ld_data;
      end
    end
  end

  assign bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_req_wen   = wen_q;
  assign bus_req_wstrb = wen_q ? (wmask_q << addr_q[1:0]) : 4'b0000;
  assign bus_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a result scoreboard.
// Bus side is driven cycle by cycle from the stimulus sequence.
module tb_lsu_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [7:0]  in_wmask;
  logic [2:0]  in_rtype;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic        bus_resp_ready;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [2:0]  out_err;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wen         (in_wen),
    .in_wmask       (in_wmask),
    .in_rtype       (in_rtype),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wen    (bus_req_wen),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_req_wdata  (bus_req_wdata),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_ready (bus_resp_ready),
    .bus_resp_rdata (bus_resp_rdata),
    .bus_resp_err   (bus_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input logic        wen,
    input logic [7:0]  wm,
    input logic [2:0]  rt,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input bit          bus,
    input int          req_wait,
    input logic [31:0] rsp_data,
    input logic        rsp_err,
    input logic [3:0]  exp_strb,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic [2:0]  exp_err,
    input int          out_wait
  );
    exp_t e;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    chk("req_valid_idle", bus_req_valid, 0);
    in_valid = 1'b1;
    in_wen   = wen;
    in_wmask = wm;
    in_rtype = rt;
    in_addr  = addr;
    in_wdata = wd;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    // scramble inputs to prove the op was latched
    in_valid = 1'b0;
    in_wen   = ~wen;
    in_wmask = 8'hFF;
    in_rtype = 3'd7;
    in_addr  = ~addr;
    in_wdata = ~wd;
    if (bus) begin
      chk("req_valid", bus_req_valid, 1);
      chk("req_addr", bus_req_addr, exp_addr);
      chk("req_wen", bus_req_wen, wen);
      chk("req_wstrb", bus_req_wstrb, exp_strb);
      chk("req_wdata", bus_req_wdata, exp_wdata);
      chk("out_valid_req", out_valid, 0);
      for (int i = 0; i < req_wait; i++) begin
        @(negedge clk);
        chk("req_hold_valid", bus_req_valid, 1);
        chk("req_hold_addr", bus_req_addr, exp_addr);
        chk("req_hold_wstrb", bus_req_wstrb, exp_strb);
        chk("req_hold_wdata", bus_req_wdata, exp_wdata);
      end
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      chk("req_valid_resp", bus_req_valid, 0);
      chk("resp_ready", bus_resp_ready, 1);
      chk("out_valid_resp", out_valid, 0);
      bus_resp_valid = 1'b1;
      bus_resp_rdata = rsp_data;
      bus_resp_err   = rsp_err;
      @(negedge clk);
      bus_resp_valid = 1'b0;
      bus_resp_err   = 1'b0;
      bus_resp_rdata = 32'h0;
      chk("resp_ready_done", bus_resp_ready, 0);
    end else begin
      chk("no_req_valid", bus_req_valid, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < out_wait; i++) begin
      @(negedge clk);
      chk("out_hold_valid", out_valid, 1);
      chk("out_hold_in_ready", in_ready, 0);
      chk("out_hold_rdata", out_rdata, exp_rdata);
      chk("out_hold_err", out_err, exp_err);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("out_rdata", out_rdata, e.rdata);
      chk("out_err", out_err, e.err);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_wen         = 1'b0;
    in_wmask       = 8'h0;
    in_rtype       = 3'd0;
    in_addr        = 32'h0;
    in_wdata       = 32'h0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    bus_resp_err   = 1'b0;
    out_ready      = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", bus_req_valid, 0);
    chk("rst_resp_ready", bus_resp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_out_ready_noeffect", out_valid, 0);

    // lb / lbu / lh / lhu / lw loads
    run_op(0, 8'h00, 3'd0, 32'h8000_0003, 32'h0, 1, 0,
           32'h80AB_CDEF, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 3'd0, 0);
    run_op(0, 8'h00, 3'd0, 32'h8000_0000, 32'h0, 1, 0,
           32'h80AB_CDEF, 0, 4'h0, 32'h0, 32'hFFFF_FFEF, 3'd0, 0);
    run_op(0, 8'h00, 3'd3, 32'h8000_0001, 32'h0, 1, 0,
           32'h80AB_CDEF, 0, 4'h0, 32'h0, 32'h0000_00CD, 3'd0, 0);
    run_op(0, 8'h00, 3'd4, 32'h8000_0002, 32'h0, 1, 0,
           32'hBEEF_1234, 0, 4'h0, 32'h0, 32'h0000_BEEF, 3'd0, 0);
    run_op(0, 8'h00, 3'd1, 32'h8000_0002, 32'h0, 1, 0,
           32'hBEEF_1234, 0, 4'h0, 32'h0, 32'hFFFF_BEEF, 3'd0, 0);
    run_op(0, 8'h00, 3'd2, 32'h8000_0004, 32'h0, 1, 0,
           32'h1234_5678, 0, 4'h0, 32'h0, 32'h1234_5678, 3'd0, 0);

    // stores: response data must not leak to out_rdata
    run_op(1, 8'h01, 3'd0, 32'h8000_0001, 32'h0000_00AA, 1, 0,
           32'hDEAD_BEEF, 0, 4'b0010, 32'h0000_AA00, 32'h0, 3'd0, 0);
    run_op(1, 8'h0F, 3'd0, 32'h8000_0000, 32'h1234_5678, 1, 0,
           32'hDEAD_BEEF, 0, 4'hF, 32'h1234_5678, 32'h0, 3'd0, 0);
    run_op(1, 8'h03, 3'd0, 32'h8000_0002, 32'h0000_BEEF, 1, 0,
           32'h0, 0, 4'b1100, 32'hBEEF_0000, 32'h0, 3'd0, 0);

    // decode errors: no bus traffic, result one cycle after accept
    run_op(1, 8'h03, 3'd0, 32'h8000_0001, 32'h0, 0, 0,
           32'h0, 0, 4'h0, 32'h0, 32'h0, 3'd2, 0);
    run_op(0, 8'h00, 3'd2, 32'h8000_0002, 32'h0, 0, 0,
           32'h0, 0, 4'h0, 32'h0, 32'h0, 3'd1, 0);
    run_op(0, 8'h00, 3'd6, 32'h8000_0000, 32'h0, 0, 0,
           32'h0, 0, 4'h0, 32'h0, 32'h0, 3'd4, 0);
    run_op(1, 8'h07, 3'd0, 32'h8000_0000, 32'h0, 0, 0,
           32'h0, 0, 4'h0, 32'h0, 32'h0, 3'd4, 0);

    // stalled request, bus error, stalled writeback
    run_op(1, 8'h01, 3'd0, 32'h8000_0007, 32'h0000_0055, 1, 5,
           32'hFFFF_FFFF, 1, 4'b1000, 32'h5500_0000, 32'h0, 3'd3, 4);
    run_op(0, 8'h00, 3'd2, 32'h8000_0004, 32'h0, 1, 5,
           32'h1111_2222, 1, 4'h0, 32'h0, 32'h0, 3'd3, 3);

    // reset while waiting for a response
    @(negedge clk);
    in_valid = 1'b1;
    in_wen   = 1'b0;
    in_rtype = 3'd2;
    in_addr  = 32'h8000_0010;
    in_wdata = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("pre_rst_resp_ready", bus_resp_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_resp_ready", bus_resp_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hCAFE_F00D;
    repeat (2) begin
      @(negedge clk);
      chk("late_resp_out_valid", out_valid, 0);
      chk("late_resp_in_ready", in_ready, 1);
      chk("late_resp_rdata", out_rdata, 0);
    end
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    run_op(0, 8'h00, 3'd2, 32'h8000_0008, 32'h0, 1, 0,
           32'h1122_3344, 0, 4'h0, 32'h0, 32'h1122_3344, 3'd0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
